// File: rtl/l2_pkg.sv
// Shared constants and state encoding for the L2-norm vector driver and its buffer.
package l2_pkg;

  localparam int NORM_LAT      = 3;   // norm block valid_in -> valid_out latency
  localparam int MAX_LEN       = 16;
  localparam int ELEM_W        = 8;
  localparam int ACC_W         = 20;
  localparam int ROOT_W        = 10;
  localparam int TIMEOUT_SLACK = 8;

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_SEND   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESULT = 3'd4
  } l2_state_e;

endpackage

// File: rtl/l2_vec_buf.sv
// DEPTH x ELEM_W register file: one write port, one read port addressed by a registered index.
module l2_vec_buf
  import l2_pkg::*;
#(
  parameter int DEPTH = MAX_LEN,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_idx,
  input  logic [ELEM_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_idx,
  output logic [ELEM_W-1:0] rd_data
);

  logic [ELEM_W-1:0] mem [DEPTH];

  // NOTE: storage is deliberately unreset; every slot is written before it is read, and a reset would turn the array into flops with reset muxes.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/l2_vec_driver.sv
// Buffers a byte vector, clears and feeds the L2-norm block, and returns its final norm.
// Optional watchdog on SEND+WAIT is compiled in with `define L2_DRV_TIMEOUT_EN.
module l2_vec_driver
  import l2_pkg::*;
#(
  parameter int DEPTH = MAX_LEN,
  parameter int LEN_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [ELEM_W-1:0] s_data,
  input  logic              s_last,
  output logic [ELEM_W-1:0] a,
  output logic              valid_in,
  output logic              norm_clear,
  input  logic [ROOT_W-1:0] g,
  input  logic              valid_out,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [ROOT_W-1:0] r_norm,
  output logic [LEN_W-1:0]  r_count,
  output logic              r_trunc,
  output logic              r_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  l2_state_e         state_q, state_d;
  logic [LEN_W-1:0]  wr_idx_q, wr_idx_d;
  logic [LEN_W-1:0]  rd_idx_q, rd_idx_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [ELEM_W-1:0] a_q, a_d;
  logic              valid_in_q, valid_in_d;
  logic              norm_clear_q, norm_clear_d;
  logic [ROOT_W-1:0] r_norm_q, r_norm_d;
  logic [LEN_W-1:0]  r_count_q, r_count_d;
  logic              r_trunc_q, r_trunc_d;
  logic              wr_en, accept, done;
  logic [ELEM_W-1:0] rd_data;

`ifdef L2_DRV_TIMEOUT_EN
  localparam int WD_W = LEN_W + 1;
  logic [WD_W-1:0] wd_q, wd_d, wd_limit;
  logic            r_err_q, r_err_d, expired;

  assign wd_limit = {1'b0, len_q} + WD_W'(TIMEOUT_SLACK);
  assign r_err    = r_err_q;
`else
  assign r_err = 1'b0;
`endif

  assign s_ready    = (state_q == ST_LOAD) && !reset;
  assign accept     = s_valid && s_ready;
  assign r_valid    = (state_q == ST_RESULT);
  assign a          = a_q;
  assign valid_in   = valid_in_q;
  assign norm_clear = norm_clear_q;
  assign r_norm     = r_norm_q;
  assign r_count    = r_count_q;
  assign r_trunc    = r_trunc_q;

  l2_vec_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx_q[AW-1:0]),
    .wr_data (s_data),
    .rd_idx  (rd_idx_q[AW-1:0]),
    .rd_data (rd_data)
  );

  // NOTE: every variable gets a default before the case so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d      = state_q;
    wr_idx_d     = wr_idx_q;
    rd_idx_d     = rd_idx_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    a_d          = '0;
    valid_in_d   = 1'b0;
    norm_clear_d = 1'b0;
    r_norm_d     = r_norm_q;
    r_count_d    = r_count_q;
    r_trunc_d    = r_trunc_q;
    wr_en        = 1'b0;
    done         = 1'b0;
`ifdef L2_DRV_TIMEOUT_EN
    wd_d         = wd_q;
    r_err_d      = r_err_q;
    expired      = 1'b0;
`endif
    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          wr_en    = 1'b1;
          wr_idx_d = wr_idx_q + LEN_W'(1);
          if (s_last || wr_idx_d == DEPTH_L) begin
            state_d      = ST_CLEAR;
            len_d        = wr_idx_d;
            r_trunc_d    = !s_last;
            norm_clear_d = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        state_d    = ST_SEND;
        valid_in_d = 1'b1;
        a_d        = rd_data;
        rd_idx_d   = rd_idx_q + LEN_W'(1);
      end
      ST_SEND, ST_WAIT: begin
        if (valid_out) cnt_d = cnt_q + LEN_W'(1);
        done = valid_out && (cnt_d == len_q);
`ifdef L2_DRV_TIMEOUT_EN
        wd_d    = wd_q + WD_W'(1);
        expired = (wd_d == wd_limit);
`endif
        if (done) begin
          state_d   = ST_RESULT;
          r_norm_d  = g;
          r_count_d = len_q;
`ifdef L2_DRV_TIMEOUT_EN
          r_err_d   = 1'b0;
        end else if (expired) begin
          state_d   = ST_RESULT;
          r_err_d   = 1'b1;
          r_norm_d  = '0;
          r_count_d = cnt_d;
`endif
        end else if (state_q == ST_SEND) begin
          // rd_idx_q already points one past the element currently on a.
          if (rd_idx_q != len_q) begin
            valid_in_d = 1'b1;
            a_d        = rd_data;
            rd_idx_d   = rd_idx_q + LEN_W'(1);
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_RESULT: begin
        if (r_ready) begin
          state_d  = ST_LOAD;
          wr_idx_d = '0;
          rd_idx_d = '0;
          len_d    = '0;
          cnt_d    = '0;
`ifdef L2_DRV_TIMEOUT_EN
          wd_d     = '0;
`endif
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_LOAD;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      a_q          <= '0;
      valid_in_q   <= 1'b0;
      norm_clear_q <= 1'b0;
      r_norm_q     <= '0;
      r_count_q    <= '0;
      r_trunc_q    <= 1'b0;
`ifdef L2_DRV_TIMEOUT_EN
      wd_q         <= '0;
      r_err_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wr_idx_q     <= wr_idx_d;
      rd_idx_q     <= rd_idx_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      valid_in_q   <= valid_in_d;
      norm_clear_q <= norm_clear_d;
      r_norm_q     <= r_norm_d;
      r_count_q    <= r_count_d;
      r_trunc_q    <= r_trunc_d;
`ifdef L2_DRV_TIMEOUT_EN
      wd_q         <= wd_d;
      r_err_q      <= r_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_l2_vec_driver.sv
// Directed bench for l2_vec_driver with a behavioural 3-cycle L2-norm block model.
module tb_l2_vec_driver;
  import l2_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              s_valid, s_ready, s_last;
  logic [ELEM_W-1:0] s_data;
  logic [ELEM_W-1:0] a;
  logic              valid_in, norm_clear, valid_out;
  logic [ROOT_W-1:0] g;
  logic              r_valid, r_ready, r_trunc, r_err;
  logic [ROOT_W-1:0] r_norm;
  logic [4:0]        r_count;
  logic              mute_vo = 1'b0;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  l2_vec_driver #(.DEPTH(16), .LEN_W(5)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .a(a), .valid_in(valid_in), .norm_clear(norm_clear),
    .g(g), .valid_out(valid_out),
    .r_valid(r_valid), .r_ready(r_ready), .r_norm(r_norm),
    .r_count(r_count), .r_trunc(r_trunc), .r_err(r_err)
  );

  // Norm block model: accumulate a*a, emit floor(sqrt(acc)) NORM_LAT cycles after valid_in.
  int       acc = 0;
  logic [2:0] pv = 3'b000;
  int       pg [3] = '{0, 0, 0};

  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  always @(posedge clk) begin
    if (norm_clear) begin
      acc <= 0;
      pv  <= 3'b000;
    end else begin
      if (valid_in) acc <= acc + int'(a) * int'(a);
      pv    <= {pv[1:0], valid_in};
      pg[0] <= isqrt(acc + (valid_in ? int'(a) * int'(a) : 0));
      pg[1] <= pg[0];
      pg[2] <= pg[1];
    end
  end
  assign valid_out = pv[2] && !mute_vo;
  assign g         = pg[2][ROOT_W-1:0];

  typedef struct {
    int n;
    int b0;
    int b1;
    int rest;
    int exp_norm;
    int exp_count;
  } vec_t;

  function automatic vec_t mk(input int n, input int b0, input int b1, input int rest, input int nrm);
    vec_t v;
    v.n = n; v.b0 = b0; v.b1 = b1; v.rest = rest; v.exp_norm = nrm; v.exp_count = n;
    return v;
  endfunction

  function automatic int elem(input vec_t v, input int i);
    return (i == 0) ? v.b0 : (i == 1) ? v.b1 : v.rest;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Returns at the falling edge of the cycle after the last accepted beat.
  task automatic send_vec(input vec_t v, input bit with_last, output int t_acc);
    int guard;
    t_acc = 0;
    for (int i = 0; i < v.n; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 8'(elem(v, i));
      s_last  = with_last && (i == v.n - 1);
      guard   = 0;
      while (!s_ready && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      if (!s_ready) check("s_ready_wait_expired", 0, 1);
      t_acc = cyc;
      @(posedge clk);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_result(output int t_r);
    int guard = 0;
    while (!r_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!r_valid) check("r_valid_wait_expired", 0, 1);
    t_r = cyc;
  endtask

  task automatic take_result();
    check("s_ready_during_result", s_ready, 0);
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
    check("s_ready_after_take", s_ready, 1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int t, tr;
    send_vec(v, 1'b1, t);
    wait_result(tr);
    check($sformatf("%s_latency", tag), tr - t, v.n + 5);
    check($sformatf("%s_norm", tag), r_norm, v.exp_norm);
    check($sformatf("%s_count", tag), r_count, v.exp_count);
    check($sformatf("%s_trunc", tag), r_trunc, 0);
    check($sformatf("%s_err", tag), r_err, 0);
    take_result();
  endtask

  vec_t tbl [10];

  initial begin
    int t, tr, stall_bad;

    tbl[0] = mk(16, 255, 255, 255, 1020);
    tbl[1] = mk(2, 12, 5, 0, 13);
    tbl[2] = mk(1, 0, 0, 0, 0);
    tbl[3] = mk(4, 2, 2, 2, 4);
    tbl[4] = mk(1, 255, 0, 0, 255);
    tbl[5] = mk(9, 100, 100, 100, 300);
    tbl[6] = mk(3, 1, 2, 2, 3);
    tbl[7] = mk(5, 10, 0, 1, 10);
    tbl[8] = mk(15, 1, 1, 1, 3);
    tbl[9] = mk(2, 6, 8, 0, 10);

    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; r_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_r_valid", r_valid, 0);
    check("rst_valid_in", valid_in, 0);
    check("rst_norm_clear", norm_clear, 0);
    check("rst_r_norm", r_norm, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_s_ready", s_ready, 1);

    // {3,4}: cycle-by-cycle clear/replay timing.
    send_vec(mk(2, 3, 4, 0, 5), 1'b1, t);
    check("v34_norm_clear", norm_clear, 1);
    check("v34_s_ready_clear", s_ready, 0);
    @(negedge clk);
    check("v34_vin0", valid_in, 1);
    check("v34_a0", a, 3);
    @(negedge clk);
    check("v34_vin1", valid_in, 1);
    check("v34_a1", a, 4);
    @(negedge clk);
    check("v34_vin_end", valid_in, 0);
    wait_result(tr);
    check("v34_latency", tr - t, 7);
    check("v34_norm", r_norm, 5);
    check("v34_count", r_count, 2);
    check("v34_trunc", r_trunc, 0);
    take_result();

    for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // 20 x 1 with no early s_last: truncates at 16, remainder forms the next vector.
    send_vec(mk(16, 1, 1, 1, 4), 1'b0, t);
    s_valid = 1'b1; s_data = 8'd1; s_last = 1'b0;
    stall_bad = 0;
    begin
      int guard = 0;
      while (!r_valid && guard < 200) begin
        if (s_ready) stall_bad = 1;
        @(negedge clk);
        guard++;
      end
    end
    tr = cyc;
    check("trunc_r_valid", r_valid, 1);
    check("trunc_stall", stall_bad, 0);
    check("trunc_latency", tr - t, 21);
    check("trunc_norm", r_norm, 4);
    check("trunc_count", r_count, 16);
    check("trunc_flag", r_trunc, 1);
    check("trunc_s_ready_result", s_ready, 0);
    r_ready = 1'b1; s_valid = 1'b0;
    @(negedge clk);
    r_ready = 1'b0;
    check("trunc_s_ready_after", s_ready, 1);
    run_vec(mk(4, 1, 1, 1, 2), "trunc_rest");

    // {7} with r_ready held low: result must hold.
    send_vec(mk(1, 7, 0, 0, 7), 1'b1, t);
    wait_result(tr);
    check("bp_norm_first", r_norm, 7);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d_valid", k), r_valid, 1);
      check($sformatf("bp_hold%0d_norm", k), r_norm, 7);
      check($sformatf("bp_hold%0d_s_ready", k), s_ready, 0);
    end
    take_result();

    // Reset in the middle of SEND for {9,9,9}.
    send_vec(mk(3, 9, 9, 9, 15), 1'b1, t);
    @(negedge clk);
    @(negedge clk);
    check("mid_send_valid_in", valid_in, 1);
    reset = 1'b1;
    #1;
    check("rst_mid_a", a, 0);
    check("rst_mid_valid_in", valid_in, 0);
    check("rst_mid_norm_clear", norm_clear, 0);
    check("rst_mid_r_valid", r_valid, 0);
    check("rst_mid_r_norm", r_norm, 0);
    check("rst_mid_r_count", r_count, 0);
    check("rst_mid_r_trunc", r_trunc, 0);
    check("rst_mid_r_err", r_err, 0);
    check("rst_mid_s_ready", s_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_s_ready_after", s_ready, 1);
    run_vec(mk(2, 6, 8, 0, 10), "after_rst");

`ifdef L2_DRV_TIMEOUT_EN
    mute_vo = 1'b1;
    send_vec(mk(1, 5, 0, 0, 0), 1'b1, t);
    wait_result(tr);
    check("to_latency_from_send", tr - (t + 2), 9);
    check("to_err", r_err, 1);
    check("to_count", r_count, 0);
    check("to_norm", r_norm, 0);
    take_result();
    mute_vo = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/l2_vec_driver.md
# l2_vec_driver

Transmit-side companion to the L2-norm datapath (byte squarer/accumulator/square-root block). Accepts a vector of unsigned bytes over a ready/valid stream and buffers it. Clears the norm block, replays the bytes to it one per cycle, counts its `valid_out` pulses, and returns the final norm on a ready/valid result port.

## Interface
Parameters:
- `DEPTH`, default 16: buffer depth and maximum vector length. Legal range 1..16; 16 × 255² = 1,040,400 fits the norm block's 20-bit accumulator.
- `LEN_W`, default 5: width of length counters; must hold `DEPTH`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `s_valid` in 1: input byte valid.
- `s_ready` out 1: driver can accept a byte.
- `s_data` in 8: unsigned vector element.
- `s_last` in 1: final element of the vector.
- `a` out 8: element to the norm block.
- `valid_in` out 1: element strobe to the norm block.
- `norm_clear` out 1: one-cycle synchronous clear to the norm block's `reset`.
- `g` in 10: norm block result.
- `valid_out` in 1: norm block per-element result strobe.
- `r_valid` out 1: result available.
- `r_ready` in 1: result consumed.
- `r_norm` out 10: captured norm.
- `r_count` out LEN_W: number of elements in the vector.
- `r_trunc` out 1: vector truncated at `DEPTH`.
- `r_err` out 1: timeout. Constant 0 unless the timeout is compiled in.

## Operation
- FSM states and transitions:
  - `LOAD`: `s_ready`=1; each handshake writes `s_data` to `buf[wr_idx]` and increments `wr_idx`. Leaves to `CLEAR` on an accepted beat with `s_last`=1, or when `wr_idx` reaches `DEPTH`.
  - `CLEAR`: exactly one cycle; `norm_clear`=1; `s_ready`=0.
  - `SEND`: runs `len` cycles. `valid_in`=1 and `a`=`buf[rd_idx]`, with `rd_idx` 0..len-1, back-to-back with no gaps.
  - `WAIT`: holds until the `valid_out` pulse count equals `len`.
  - `RESULT`: `r_valid`=1; on `r_ready` returns to `LOAD` with all indices and counters zeroed.
- `valid_out` pulses are counted in both `SEND` and `WAIT`. Pulses seen in `LOAD`, `CLEAR` or `RESULT` are ignored.
- On the cycle the pulse count reaches `len`:
  - `r_norm` <= `g`;
  - `r_count` <= `len`;
  - FSM goes to `RESULT`.
- Truncation: if the `DEPTH`-th byte is accepted with `s_last`=0, `r_trunc`=1 for that result. Remaining upstream bytes stall (`s_ready`=0) until the next `LOAD`; they then form the next vector.
- `s_ready` is 0 in every state except `LOAD`. Result outputs hold stable while `r_valid`=1 and `r_ready`=0.
- The minimum vector is 1 element. No zero-length vector exists.
- Reset (any state):
  - FSM returns to `LOAD`; buffer contents are discarded.
  - `s_ready` reads 0 while `reset` is asserted, 1 from the first cycle after release.
  - All of `a`, `valid_in`, `norm_clear`, `r_valid`, `r_norm`, `r_count`, `r_trunc` and `r_err` are 0.
  - The driver does not depend on the norm block's prior state, because every vector begins with `CLEAR`.

## Timing
- Final `s_last` beat accepted at cycle t:
  - `CLEAR` at t+1;
  - `valid_in` at t+2..t+1+len;
  - last `valid_out` at t+len+4, since the norm block latency is 3 cycles from `valid_in` to `valid_out`;
  - `r_valid` at t+len+5.
- `a`/`valid_in`/`norm_clear` are registered outputs. `s_ready` is decoded from state.
- A result handshake at cycle u gives `s_ready`=1 at u+1.

## Configuration
- `L2_DRV_TIMEOUT_EN` defined:
  - A watchdog counts cycles spent in `SEND`+`WAIT`.
  - If it reaches len+8 before the pulse count reaches `len`, the FSM goes to `RESULT` with `r_err`=1, `r_norm`=0 and `r_count`=pulses seen.
- Not defined: no watchdog, `WAIT` holds indefinitely, `r_err` is tied 0.

## Structure
- Package `l2_pkg` holds:
  - the state enum;
  - `NORM_LAT`=3;
  - `MAX_LEN`=16;
  - `ELEM_W`=8, `ACC_W`=20, `ROOT_W`=10;
  - `TIMEOUT_SLACK`=8.
- Sub-module `l2_vec_buf`: DEPTH×8 register file with a write port and a synchronous-index read port. It has no reset on its storage.

## Test plan
- Vector {3,4} -> `r_norm`=5, `r_count`=2, `r_valid` 7 cycles after the `s_last` accept, `r_trunc`=0.
- 16 × 255 with `s_last` on the 16th byte -> `r_norm`=1020 (√1,040,400), `r_count`=16, `r_trunc`=0.
- 20 × 1 with no `s_last` until byte 20:
  - first result: `r_norm`=4, `r_count`=16, `r_trunc`=1;
  - after the handshake the remaining 4 bytes give a second result: `r_norm`=2, `r_count`=4.
- {7} with `r_ready` held low 5 cycles -> `r_valid` and `r_norm`=7 stable for 5 cycles; `s_ready`=0 until the cycle after `r_ready`.
- `reset` pulsed mid-`SEND` of {9,9,9} -> all outputs 0 immediately, `s_ready`=1 after release; then {6,8} -> `r_norm`=10.
- With `L2_DRV_TIMEOUT_EN` and `valid_out` tied 0, vector {5} -> `r_valid` with `r_err`=1 and `r_count`=0, 9 cycles after entering `SEND`.
